// File: rtl/mult_seq_ctrl_pkg.sv
// rtl/mult_seq_ctrl_pkg.sv - shared state encodings and width limits for the shift-add multiplier sequencer
//
// Purpose : 3-bit state encodings for mult_seq_ctrl, the legal operand
//           width range and a helper that sizes the iteration counter.
// Ports   : none (package).
package mult_seq_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_CLR  = 3'd1,
    ST_LOAD = 3'd2,
    ST_ADD  = 3'd3,
    ST_SHP  = 3'd4,
    ST_SHB  = 3'd5,
    ST_DONE = 3'd6
  } state_t;

  localparam int WIDTH_MIN = 2;
  localparam int WIDTH_MAX = 16;

  // Bits needed to hold WIDTH-1; never less than one.
  function automatic int cnt_width(input int w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

endpackage

// File: rtl/mult_seq_ctrl_iter_counter.sv
// rtl/mult_seq_ctrl_iter_counter.sv - bit-iteration down counter for the multiplier sequencer
//
// Purpose : counts remaining add steps. Loads WIDTH-1, decrements on dec,
//           flags zero when the last add step is reached.
// Ports   : clk, reset (async, active-high)
//           load  - synchronous load of WIDTH-1 (wins over dec)
//           dec   - decrement by one (saturates at zero)
//           count - current value
//           zero  - count == 0
module iter_counter #(
  parameter int WIDTH = 4,
  parameter int CW    = 2
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          load,
  input  logic          dec,
  output logic [CW-1:0] count,
  output logic          zero
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= CW'(WIDTH - 1);
    end else if (dec && (count != '0)) begin
      count <= count - CW'(1);
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/mult_seq_ctrl.sv
// rtl/mult_seq_ctrl.sv - start/busy/done sequencer driving the shift-add multiplier datapath
//
// Purpose : runs CLR, LOAD, then WIDTH add steps separated by accumulator and
//           multiplier shifts, gating each add with the multiplier LSB.
// Ports   : clk, reset (async, active-high)
//           start, abort      - requester handshake inputs
//           b0                - multiplier LSB from datapath (used in ADD only)
//           clr, ld, ldp,
//           shp, shb          - datapath strobes, at most one high per cycle
//           busy, done        - status; done is a one-cycle pulse
//           iter              - current bit index, 0 outside the add loop
module mult_seq_ctrl #(
  parameter int WIDTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  input  logic                       abort,
  input  logic                       b0,
  output logic                       clr,
  output logic                       ld,
  output logic                       ldp,
  output logic                       shp,
  output logic                       shb,
  output logic                       busy,
  output logic                       done,
  output logic [$clog2(WIDTH)-1:0]   iter
);

  import mult_seq_ctrl_pkg::*;

  localparam int CW = cnt_width(WIDTH);

  if (WIDTH < WIDTH_MIN || WIDTH > WIDTH_MAX) begin : g_bad_width
    $error("mult_seq_ctrl: WIDTH must be in 2..16");
  end

  state_t        state;
  state_t        state_nxt;
  logic          cnt_load;
  logic          cnt_dec;
  logic [CW-1:0] count;
  logic          cnt_zero;

  iter_counter #(
    .WIDTH (WIDTH),
    .CW    (CW)
  ) u_iter_counter (
    .clk   (clk),
    .reset (reset),
    .load  (cnt_load),
    .dec   (cnt_dec),
    .count (count),
    .zero  (cnt_zero)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = ST_IDLE;
    cnt_load  = 1'b0;
    cnt_dec   = 1'b0;
    clr       = 1'b0;
    ld        = 1'b0;
    ldp       = 1'b0;
    shp       = 1'b0;
    shb       = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;

    case (state)
      ST_IDLE: begin
        // abort beats start so a cancelled request never launches a run
        state_nxt = (start && !abort) ? ST_CLR : ST_IDLE;
      end
      ST_CLR: begin
        clr       = 1'b1;
        busy      = 1'b1;
        cnt_load  = 1'b1;
        state_nxt = ST_LOAD;
      end
      ST_LOAD: begin
        ld        = 1'b1;
        busy      = 1'b1;
        state_nxt = ST_ADD;
      end
      ST_ADD: begin
        // only the add strobe looks at an input; everything else is state-decoded
        ldp       = b0;
        busy      = 1'b1;
        state_nxt = cnt_zero ? ST_DONE : ST_SHP;
      end
      ST_SHP: begin
        shp       = 1'b1;
        busy      = 1'b1;
        state_nxt = ST_SHB;
      end
      ST_SHB: begin
        shb       = 1'b1;
        busy      = 1'b1;
        cnt_dec   = 1'b1;
        state_nxt = ST_ADD;
      end
      ST_DONE: begin
        done      = 1'b1;
        state_nxt = ST_IDLE;
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase

    if (abort && (state != ST_IDLE)) begin
      state_nxt = ST_IDLE;
    end
  end

  // Bit index counts up while the counter counts down; zero outside the loop.
  always_comb begin
    iter = '0;
    if (state == ST_ADD || state == ST_SHP || state == ST_SHB) begin
      iter = $clog2(WIDTH)'(CW'(WIDTH - 1) - count);
    end
  end

endmodule

// File: tb/tb_mult_seq_ctrl.sv
// tb/tb_mult_seq_ctrl.sv - table-driven bench for the multiplier sequencer
module tb_mult_seq_ctrl;

  localparam int W  = 4;
  localparam int CW = $clog2(W);

  // expected output vector order: {clr, ld, ldp, shp, shb, busy, done}
  localparam logic [6:0] O_IDLE = 7'b0000000;
  localparam logic [6:0] O_CLR  = 7'b1000010;
  localparam logic [6:0] O_LD   = 7'b0100010;
  localparam logic [6:0] O_LDP  = 7'b0010010;
  localparam logic [6:0] O_ADD0 = 7'b0000010;
  localparam logic [6:0] O_SHP  = 7'b0001010;
  localparam logic [6:0] O_SHB  = 7'b0000110;
  localparam logic [6:0] O_DONE = 7'b0000001;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic          abort;
  logic          b0;
  logic          clr, ld, ldp, shp, shb, busy, done;
  logic [CW-1:0] iter;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic          s;
    logic          a;
    logic          b;
    logic [6:0]    exp;
    logic [CW-1:0] it;
  } vec_t;

  vec_t vecs[$];

  mult_seq_ctrl #(.WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .abort (abort),
    .b0    (b0),
    .clr   (clr),
    .ld    (ld),
    .ldp   (ldp),
    .shp   (shp),
    .shb   (shb),
    .busy  (busy),
    .done  (done),
    .iter  (iter)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_out(input string name, input logic [6:0] e, input logic [CW-1:0] it);
    logic [6:0] act;
    act = {clr, ld, ldp, shp, shb, busy, done};
    checks++;
    if (act !== e || iter !== it) begin
      errors++;
      $display("FAIL %s: got clr/ld/ldp/shp/shb/busy/done=%b iter=%0d, want %b iter=%0d",
               name, act, iter, e, it);
    end
  endtask

  task automatic add(input logic s, input logic a, input logic b, input logic [6:0] e, input int it);
    vec_t v;
    v.s   = s;
    v.a   = a;
    v.b   = b;
    v.exp = e;
    v.it  = CW'(it);
    vecs.push_back(v);
  endtask

  // One complete run: IDLE cycle with start, then the hand-derived strobe order.
  task automatic add_run(input logic [W-1:0] pat, input logic hold);
    add(1'b1, 1'b0, 1'b0, O_IDLE, 0);
    add(hold, 1'b0, 1'b0, O_CLR, 0);
    add(hold, 1'b0, 1'b0, O_LD, 0);
    for (int k = 0; k < W; k++) begin
      add(hold, 1'b0, pat[k], pat[k] ? O_LDP : O_ADD0, k);
      if (k < W - 1) begin
        add(hold, 1'b0, 1'b0, O_SHP, k);
        add(hold, 1'b0, 1'b0, O_SHB, k);
      end
    end
    add(hold, 1'b0, 1'b0, O_DONE, 0);
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    abort = 1'b0;
    b0    = 1'b0;

    // reset then idle
    for (int i = 0; i < 10; i++) add(1'b0, 1'b0, 1'b0, O_IDLE, 0);
    // full run, b0 = 1 throughout
    add_run(4'b1111, 1'b0);
    // add gating: b0 = 1,0,1,0 over the four ADD cycles
    add_run(4'b0101, 1'b0);
    add(1'b0, 1'b0, 1'b0, O_IDLE, 0);
    // abort in the second SHP cycle
    add(1'b1, 1'b0, 1'b0, O_IDLE, 0);
    add(1'b0, 1'b0, 1'b0, O_CLR, 0);
    add(1'b0, 1'b0, 1'b0, O_LD, 0);
    add(1'b0, 1'b0, 1'b1, O_LDP, 0);
    add(1'b0, 1'b0, 1'b0, O_SHP, 0);
    add(1'b0, 1'b0, 1'b0, O_SHB, 0);
    add(1'b0, 1'b0, 1'b1, O_LDP, 1);
    add(1'b0, 1'b1, 1'b0, O_SHP, 1);
    add(1'b0, 1'b0, 1'b0, O_IDLE, 0);
    add(1'b0, 1'b0, 1'b0, O_IDLE, 0);
    // complete run after the abort
    add_run(4'b1111, 1'b0);
    // start held high through a run, then back-to-back start right after DONE
    add_run(4'b1111, 1'b1);
    add_run(4'b1010, 1'b0);
    // start and abort together in IDLE
    add(1'b1, 1'b1, 1'b0, O_IDLE, 0);
    add(1'b0, 1'b0, 1'b0, O_IDLE, 0);
    add(1'b0, 1'b1, 1'b0, O_IDLE, 0);
    add(1'b0, 1'b0, 1'b0, O_IDLE, 0);

    #12;
    check_out("reset_state", O_IDLE, 0);
    tick();
    reset = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      start = vecs[i].s;
      abort = vecs[i].a;
      b0    = vecs[i].b;
      #1;
      check_out($sformatf("vec%0d", i), vecs[i].exp, vecs[i].it);
      tick();
    end
    start = 1'b0;
    abort = 1'b0;
    b0    = 1'b0;

    // asynchronous reset in the second ADD cycle
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    tick();
    tick();
    tick();
    b0 = 1'b1;
    #1;
    check_out("pre_reset_add", O_LDP, 1);
    #1;
    reset = 1'b1;
    #1;
    check_out("async_reset_now", O_IDLE, 0);
    tick();
    reset = 1'b0;
    b0    = 1'b0;
    #1;
    check_out("post_reset_idle0", O_IDLE, 0);
    tick();
    #1;
    check_out("post_reset_idle1", O_IDLE, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
